// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit for the ysyx_22050133 RV64 pipeline.
// Holds the fetch PC, issues one 4-byte read per instruction on a 64-bit AXI
// read channel, and presents pc_out/inst to IF/ID under valid/ready.
// Optional one-entry line buffer: define YSYX_22050133_IFU_LINEBUF_EN.
module ysyx_22050133_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [63:0] pc_out,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        inst_valid_q;
  logic [63:0] pc_out_q;
  logic [31:0] inst_q;
  logic        inst_err_q;
  logic        drop_q;

  logic [63:0] redir_pc_d;
  logic [63:0] seq_pc_d;
  logic [31:0] beat_word_d;
  logic        lb_hit_d;
  logic [31:0] lb_word_d;
  logic        unused_redirect_lsb;

  // Redirect targets are word aligned; the two low bits are dropped here.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Next-PC candidates and the 32-bit half of the returned beat.
  always_comb begin
    redir_pc_d  = {redirect_pc[63:2], 2'b00};
    seq_pc_d    = pc_q + 64'd4;
    beat_word_d = pc_q[2] ? rdata[63:32] : rdata[31:0];
  end

`ifdef YSYX_22050133_IFU_LINEBUF_EN
  logic        lb_valid_q;
  logic [60:0] lb_tag_q;
  logic [63:0] lb_data_q;

  assign lb_hit_d  = lb_valid_q && (lb_tag_q == seq_pc_d[63:3]);
  assign lb_word_d = seq_pc_d[2] ? lb_data_q[63:32] : lb_data_q[31:0];

  // Capture every accepted OKAY beat; any redirect makes the buffer untrusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else if (redirect_valid) begin
      lb_valid_q <= 1'b0;
    end else if (state_q == S_R && rvalid && !drop_q && rresp == 2'b00) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= pc_q[63:3];
      lb_data_q  <= rdata;
    end
  end
`else
  assign lb_hit_d  = 1'b0;
  assign lb_word_d = 32'h0000_0000;
`endif

  // Fetch FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      araddr_q     <= RESET_PC;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      pc_out_q     <= RESET_PC;
      inst_q       <= 32'h0000_0013;
      inst_err_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_AR;
          arvalid_q <= 1'b1;
          if (redirect_valid) begin
            pc_q     <= redir_pc_d;
            araddr_q <= redir_pc_d;
          end else begin
            araddr_q <= pc_q;
          end
        end
        S_AR: begin
          // The address beat always completes at the issued address.
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
          if (redirect_valid) begin
            pc_q   <= redir_pc_d;
            drop_q <= 1'b1;
          end
        end
        S_R: begin
          if (redirect_valid) pc_q <= redir_pc_d;
          if (rvalid) begin
            rready_q <= 1'b0;
            if (redirect_valid || drop_q) begin
              // Beat belongs to a squashed path: refetch at the current PC.
              drop_q    <= 1'b0;
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
              araddr_q  <= redirect_valid ? redir_pc_d : pc_q;
            end else begin
              state_q      <= S_HOLD;
              inst_valid_q <= 1'b1;
              pc_out_q     <= pc_q;
              inst_q       <= beat_word_d;
              inst_err_q   <= (rresp != 2'b00);
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            // Redirect wins over a same-cycle accept.
            inst_valid_q <= 1'b0;
            pc_q         <= redir_pc_d;
            araddr_q     <= redir_pc_d;
            arvalid_q    <= 1'b1;
            state_q      <= S_AR;
          end else if (inst_ready) begin
            pc_q <= seq_pc_d;
            if (lb_hit_d) begin
              pc_out_q   <= seq_pc_d;
              inst_q     <= lb_word_d;
              inst_err_q <= 1'b0;
            end else begin
              inst_valid_q <= 1'b0;
              araddr_q     <= seq_pc_d;
              arvalid_q    <= 1'b1;
              state_q      <= S_AR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_valid = inst_valid_q;
  assign pc_out     = pc_out_q;
  assign inst       = inst_q;
  assign inst_err   = inst_err_q;
  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arsize     = 3'b010;
  assign rready     = rready_q;

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Self-checking bench for ysyx_22050133_ifu: AXI slave model, fetch-stream
// reference model, directed vector table and randomized traffic.
module tb_ysyx_22050133_ifu;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [63:0] pc_out;
  logic [31:0] inst;
  logic        inst_err;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [2:0]  arsize;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  ysyx_22050133_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(inst_valid), .pc_out(pc_out),
    .inst(inst), .inst_err(inst_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus knobs (percent probabilities) and pending redirect request
  int ar_pct = 100, r_pct = 100, rdy_pct = 0;
  logic        redir_v = 1'b0;
  logic [63:0] redir_target = '0;

  // slave / reference model state
  bit          r_pending = 0;
  logic [63:0] pend_addr = '0;
  logic [63:0] err_addr = 64'h1;
  logic [63:0] model_pc = RESET_PC;
  bit          prev_ar_wait = 0, prev_arvalid = 0, prev_redir = 0;
  logic [63:0] prev_araddr = '0;
  int          idle_cycles = 0, ar_fires = 0, handoffs = 0;

  function automatic logic [63:0] mem_line(input logic [63:0] a);
    logic [63:0] l;
    logic [31:0] h;
    l = {a[63:3], 3'b000};
    if (l == 64'h8000_0000) return 64'h0000_0093_0000_0013;
    h = (l[31:0] * 32'h9E37_79B1) ^ l[63:32];
    return {h ^ 32'h5A5A_0F0F, ~h + l[34:3]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] l;
    l = mem_line(a);
    return a[2] ? l[63:32] : l[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the negedge, advance the model, check at the next negedge.
  task automatic step();
    bit hand;
    arready        = (int'($urandom_range(99)) < ar_pct);
    rvalid         = r_pending && (int'($urandom_range(99)) < r_pct);
    rdata          = rvalid ? mem_line(pend_addr) : {$urandom, $urandom};
    rresp          = (rvalid && pend_addr == err_addr) ? 2'b10 : 2'b00;
    inst_ready     = (int'($urandom_range(99)) < rdy_pct);
    redirect_valid = redir_v;
    redirect_pc    = redir_target;
    redir_v        = 1'b0;

    hand = inst_valid && inst_ready && !redirect_valid;
    if (redirect_valid) model_pc = {redirect_pc[63:2], 2'b00};
    else if (hand) model_pc = model_pc + 64'd4;
    if (hand) handoffs++;
    if (hand || redirect_valid) idle_cycles = 0;
    else idle_cycles++;

    prev_ar_wait = arvalid && !arready;
    prev_araddr  = araddr;
    prev_arvalid = arvalid;
    prev_redir   = redirect_valid;
    if (rready && rvalid) r_pending = 0;
    if (arvalid && arready) begin
      ar_fires++;
      chk("single_outstanding", 64'(r_pending), 64'd0);
      r_pending = 1;
      pend_addr = araddr;
    end

    @(posedge clk);
    @(negedge clk);

    if (prev_ar_wait) begin
      chk("arvalid_held", 64'(arvalid), 64'd1);
      chk("araddr_stable", araddr, prev_araddr);
    end
    if (prev_redir) chk("redirect_squash", 64'(inst_valid), 64'd0);
    if (arvalid && !prev_arvalid) chk("araddr_issue", araddr, model_pc);
    if (inst_valid) begin
      chk("pc_out", pc_out, model_pc);
      chk("inst", 64'(inst), 64'(mem_word(model_pc)));
      chk("inst_err", 64'(inst_err), 64'(model_pc == err_addr));
    end
    if (idle_cycles > 200) begin
      checks++;
      errors++;
      $display("FAIL liveness: %0d cycles without progress, required <= 200", idle_cycles);
      idle_cycles = 0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; rdata = '0; rresp = 2'b00;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    r_pending = 0; model_pc = RESET_PC;
    prev_ar_wait = 0; prev_arvalid = 0; prev_redir = 0; idle_cycles = 0;
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_pc_out", pc_out, RESET_PC);
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_inst_err", 64'(inst_err), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_araddr", araddr, RESET_PC);
    chk("arsize", 64'(arsize), 64'd2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: inst_valid not seen within 20 cycles", name);
    end
  endtask

  task automatic accept(input string name);
    rdy_pct = 100;
    step();
    rdy_pct = 0;
    wait_valid(name);
  endtask

  typedef struct {
    bit          ir;
    bit          e_iv;
    bit          e_arv;
    bit          e_rr;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int base, hbase, n;
    // zero-wait fetch after reset release, then a 4-cycle hold and one accept
    tbl[0] = '{0, 0, 1, 0, RESET_PC, 32'h13};
    tbl[1] = '{0, 0, 0, 1, RESET_PC, 32'h13};
    tbl[2] = '{0, 1, 0, 0, RESET_PC, 32'h13};
    for (int i = 3; i < 7; i++) tbl[i] = '{0, 1, 0, 0, RESET_PC, 32'h13};
`ifdef YSYX_22050133_IFU_LINEBUF_EN
    tbl[7] = '{1, 1, 0, 0, 64'h8000_0004, 32'h93};
    tbl[8] = '{0, 1, 0, 0, 64'h8000_0004, 32'h93};
    tbl[9] = '{0, 1, 0, 0, 64'h8000_0004, 32'h93};
`else
    tbl[7] = '{1, 0, 1, 0, RESET_PC, 32'h13};
    tbl[8] = '{0, 0, 0, 1, RESET_PC, 32'h13};
    tbl[9] = '{0, 1, 0, 0, 64'h8000_0004, 32'h93};
`endif

    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      rdy_pct = tbl[i].ir ? 100 : 0;
      step();
      chk($sformatf("vec%0d_inst_valid", i), 64'(inst_valid), 64'(tbl[i].e_iv));
      chk($sformatf("vec%0d_arvalid", i), 64'(arvalid), 64'(tbl[i].e_arv));
      chk($sformatf("vec%0d_rready", i), 64'(rready), 64'(tbl[i].e_rr));
      chk($sformatf("vec%0d_pc_out", i), pc_out, tbl[i].e_pc);
      chk($sformatf("vec%0d_inst", i), 64'(inst), 64'(tbl[i].e_inst));
      $display("vec %0d: iv=%0b arvalid=%0b rready=%0b pc=%h inst=%h", i, inst_valid, arvalid, rready, pc_out, inst);
    end

    // arready held low for 5 cycles
    rdy_pct = 100;
    step();
    rdy_pct = 0;
    ar_pct = 0;
    base = ar_fires;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ar_stall_arvalid", 64'(arvalid), 64'd1);
      chk("ar_stall_araddr", araddr, 64'h8000_0008);
    end
    ar_pct = 100;
    wait_valid("ar_stall_fetch");
    chk("ar_stall_handshakes", 64'(ar_fires - base), 64'd1);
    chk("ar_stall_pc", pc_out, 64'h8000_0008);
    $display("ar stall: pc=%h inst=%h", pc_out, inst);

    // error response applies to that PC only
    err_addr = 64'h8000_0010;
    accept("err_prev");
    chk("err_prev_pc", pc_out, 64'h8000_000C);
    accept("err_pc");
    chk("err_pc", pc_out, 64'h8000_0010);
    chk("err_flag", 64'(inst_err), 64'd1);
    accept("err_next");
    chk("err_next_flag", 64'(inst_err), 64'd0);
    $display("err resp: pc=%h err=%0b", pc_out, inst_err);

    // redirect while a read beat is outstanding
    r_pct = 0;
    rdy_pct = 100;
    step();
    rdy_pct = 0;
    step();
    chk("redir_r_in_r", 64'(rready), 64'd1);
    redir_v = 1'b1;
    redir_target = 64'h8000_0102;
    step();
    chk("redir_r_wait", 64'(rready), 64'd1);
    chk("redir_r_iv", 64'(inst_valid), 64'd0);
    r_pct = 100;
    step();
    chk("redir_r_arvalid", 64'(arvalid), 64'd1);
    chk("redir_r_araddr", araddr, 64'h8000_0100);
    wait_valid("redir_r_fetch");
    chk("redir_r_pc", pc_out, 64'h8000_0100);
    $display("redirect in R: pc=%h inst=%h", pc_out, inst);

    // reset with a read outstanding
    r_pct = 0;
    rdy_pct = 100;
    n = 0;
    while (!rready && n < 10) begin
      step();
      n++;
    end
    chk("midrst_outstanding", 64'(rready), 64'd1);
    do_reset(2);
    r_pct = 100;
    rdy_pct = 0;
    wait_valid("midrst_fetch");
    chk("midrst_pc", pc_out, RESET_PC);
    chk("midrst_inst", 64'(inst), 64'h13);
    $display("reset mid-read: pc=%h inst=%h", pc_out, inst);

    // redirect in HOLD beats a simultaneous accept; forces a fresh read
    redir_v = 1'b1;
    redir_target = 64'h8000_0007;
    rdy_pct = 100;
    step();
    chk("redir_hold_iv", 64'(inst_valid), 64'd0);
    chk("redir_hold_arvalid", 64'(arvalid), 64'd1);
    chk("redir_hold_araddr", araddr, 64'h8000_0004);
    rdy_pct = 0;
    wait_valid("redir_hold_fetch");
    chk("redir_hold_pc", pc_out, 64'h8000_0004);
    chk("redir_hold_inst", 64'(inst), 64'h93);
    $display("redirect in HOLD: pc=%h inst=%h", pc_out, inst);

    // sequential fetch of 8 instructions: count AXI reads
    do_reset(2);
    rdy_pct = 100;
    base = ar_fires;
    hbase = handoffs;
    n = 0;
    while (handoffs - hbase < 8 && n < 100) begin
      step();
      n++;
    end
    chk("seq_handoffs", 64'(handoffs - hbase), 64'd8);
`ifdef YSYX_22050133_IFU_LINEBUF_EN
    chk("seq_reads", 64'(ar_fires - base), 64'd4);
`else
    chk("seq_reads", 64'(ar_fires - base), 64'd8);
`endif
    $display("sequential: %0d instructions, %0d reads", handoffs - hbase, ar_fires - base);

    // randomized traffic against the reference model
    err_addr = 64'h8000_0040;
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) begin
        ar_pct  = 30 + int'($urandom_range(70));
        r_pct   = 30 + int'($urandom_range(70));
        rdy_pct = 30 + int'($urandom_range(70));
      end
      if ($urandom_range(99) < 4) begin
        redir_v = 1'b1;
        if ($urandom_range(7) == 0) redir_target = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(7));
        else redir_target = 64'h8000_0000 + 64'($urandom_range(511));
      end
      step();
      if (inst_valid && inst_ready) $display("random: pc=%h inst=%h err=%0b", pc_out, inst, inst_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22050133_ifu.md
# ysyx_22050133_ifu

Instruction fetch unit for the ysyx_22050133 pipelined RV64 core. Holds the architectural fetch PC, issues one 4-byte AXI read per instruction on a 64-bit read channel, extracts the 32-bit word, and presents `pc`/`inst` to the IF/ID pipeline register under a valid/ready handshake. Takes redirects (branch, jump, ecall/mret) from EX, and stalls while decode asserts its hazard back-pressure.

## Interface
- `RESET_PC`, 64'h8000_0000, PC after reset.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `redirect_valid` input 1: take `redirect_pc` as the next fetch PC.
- `redirect_pc` input 64: target; bits [1:0] ignored and forced to 0.
- `inst_ready` input 1: downstream accepts; driven low while decode reports a hazard.
- `inst_valid` output 1: `pc_out`/`inst` valid.
- `pc_out` output 64: PC of `inst`.
- `inst` output 32: fetched instruction.
- `inst_err` output 1: returned response was not OKAY; qualified by `inst_valid`.
- `arvalid` output 1, `arready` input 1, `araddr` output 64, `arsize` output 3 (constant 3'b010): AXI read address.
- `rvalid` input 1, `rready` output 1, `rdata` input 64, `rresp` input 2: AXI read data.

## Operation
- States: IDLE, AR, R, HOLD.
- IDLE: entered only from reset; next cycle → AR.
- AR: `arvalid`=1, `araddr` = registered fetch address, stable until `arvalid & arready`; then → R. `arvalid` is never withdrawn before the handshake.
- R: `rready`=1. On `rvalid`: `inst` = `pc[2] ? rdata[63:32] : rdata[31:0]`, `inst_err` = (`rresp`!=0), → HOLD. If drop flag set: data discarded, drop cleared, → AR.
- HOLD: `inst_valid`=1, outputs stable. On `inst_ready`: `pc` ← `pc`+4, → AR.
- Redirect (highest priority, any state but IDLE): `pc` ← `redirect_pc` next cycle, `inst_valid` low next cycle.
  - HOLD: → AR; redirect beats a simultaneous `inst_ready` (accepted instruction is squashed downstream).
  - AR: address handshake still completes at the old address; drop flag set; → R as normal.
  - R: drop flag set; if `rvalid` in the same cycle, that beat is dropped and → AR.
  - Second redirect while drop pending: `pc` updates, single drop flag still covers the one outstanding beat.
- At most one outstanding read; `pc` wraps modulo 2^64.
- Reset mid-transaction: all state cleared; the bench must not return a stale R beat after reset (AXI master reset semantics).

## Timing
- Reset values: `inst_valid`=0, `pc_out`=`RESET_PC`, `inst`=32'h0000_0013, `inst_err`=0, `arvalid`=0, `rready`=0, `araddr`=`RESET_PC`, drop=0, state IDLE.
- Zero-wait memory (`arready`, `rvalid` high): AR cycle, R cycle, HOLD cycle → first `inst_valid` at cycle 3 after reset release; steady throughput 1 inst / 3 cycles.
- All outputs registered; no combinational path from AXI inputs or `inst_ready` to any output.
- Redirect → `arvalid` at new address: 1 cycle from HOLD/IDLE, after outstanding beat otherwise.

## Configuration
- `YSYX_22050133_IFU_LINEBUF_EN` defined: one-entry 64-bit line buffer (tag = pc[63:3], valid bit). Filled on every non-dropped OKAY R beat. In HOLD, on `inst_ready` with `pc`+4 hitting the buffer: stay in HOLD, present buffered word next cycle, no AXI read → 1 inst/cycle for the second word of each line. Invalidated by reset and by every redirect.
- Undefined: no buffer; every instruction issues an AXI read.

## Test plan
- Reset release, zero-wait memory returning 64'h0000_0093_0000_0013 for 0x8000_0000 → cycle 3: `pc_out`=0x8000_0000, `inst`=0x00000013; next `pc_out`=0x8000_0004, `inst`=0x00000093.
- `arready` low 5 cycles → `arvalid` high and `araddr` constant throughout, single handshake.
- `inst_ready` low 4 cycles in HOLD → `pc_out`/`inst` frozen, no new `arvalid`.
- Redirect to 0x8000_0102 while in R → outstanding beat dropped, next `araddr`=0x8000_0100, `inst_valid` only for 0x8000_0100.
- `rresp`=2'b10 → `inst_valid`=1, `inst_err`=1 for that PC only.
- With `YSYX_22050133_IFU_LINEBUF_EN`: sequential fetch 0x8000_0000..0x8000_001C → 4 AXI reads for 8 instructions; redirect to 0x8000_0004 forces a fresh read.
